// File: rtl/switch_capture.sv
// Purpose: capture the synchronized switch bank on each accepted click for CPU polling over MMIO.
// Latency: click high at edge N -> data/valid/click_cnt updated at that edge; sw needs 2 cycles to synchronize.
// Backpressure: none; a click while FULL sets sticky overrun (replace or drop per OVERWRITE), a read frees the register.
module switch_capture #(
  parameter int SW_W      = 16,
  parameter bit OVERWRITE = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             click,
  input  logic [SW_W-1:0]  sw,
  input  logic             rd_en,
  output logic [SW_W-1:0]  data,
  output logic             valid,
  output logic             overrun,
  output logic [CNT_W-1:0] click_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [SW_W-1:0]   sw_meta;
  logic [SW_W-1:0]   sw_s;
  logic              click_d;
  logic              acc;
  logic [SW_W-1:0]   data_q;
  logic [SW_W-1:0]   data_nxt;
  logic              ovr_q;
  logic              ovr_nxt;
  logic [CNT_W-1:0]  cnt_q;

  // Two-flop synchronizer: sw is asynchronous, captures only ever see sw_s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_s    <= '0;
    end else begin
      sw_meta <= sw;
      sw_s    <= sw_meta;
    end
  end

  // Remember last click level so a long pulse is accepted only on its rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      click_d <= 1'b0;
    end else begin
      click_d <= click;
    end
  end

  assign acc = click & ~click_d;

  // State, data and overrun registers; data is never touched by a read so the CPU can sample it during rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      data_q  <= data_nxt;
      ovr_q   <= ovr_nxt;
    end
  end

  // Next-state decode: reads free the register, clicks fill it; a simultaneous read+click
  // consumes the old value, captures the new one and clears overrun (clear wins over set).
  always_comb begin
    state_nxt = state_q;
    data_nxt  = data_q;
    ovr_nxt   = ovr_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          data_nxt  = sw_s;
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (acc && rd_en) begin
          data_nxt = sw_s;
          ovr_nxt  = 1'b0;
        end else if (acc) begin
          ovr_nxt = 1'b1;
          if (OVERWRITE) begin
            data_nxt = sw_s;
          end
        end else if (rd_en) begin
          state_nxt = EMPTY;
          ovr_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Count every accepted click regardless of state; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (acc) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign data      = data_q;
  assign valid     = (state_q == FULL);
  assign overrun   = ovr_q;
  assign click_cnt = cnt_q;

endmodule

// File: tb/tb_switch_capture.sv
// Directed bench: two instances (OVERWRITE=1 and OVERWRITE=0) share stimulus.
// Inputs driven 1 time unit after the rising edge; outputs checked at the same point.
// Every check is an immediate assertion; a summary line closes the run.
module tb_switch_capture;

  logic        clk;
  logic        rst_n;
  logic        click;
  logic [15:0] sw;
  logic        rd_en;

  logic [15:0] d1_data;
  logic        d1_valid;
  logic        d1_ovr;
  logic [7:0]  d1_cnt;
  logic [15:0] d0_data;
  logic        d0_valid;
  logic        d0_ovr;
  logic [7:0]  d0_cnt;

  int n_chk;
  int n_pass;

  switch_capture #(.SW_W(16), .OVERWRITE(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .click(click), .sw(sw), .rd_en(rd_en),
    .data(d1_data), .valid(d1_valid), .overrun(d1_ovr), .click_cnt(d1_cnt)
  );

  switch_capture #(.SW_W(16), .OVERWRITE(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .click(click), .sw(sw), .rd_en(rd_en),
    .data(d0_data), .valid(d0_valid), .overrun(d0_ovr), .click_cnt(d0_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_both(input string tag, input logic [15:0] e_data, input logic e_valid,
                          input logic e_ovr, input logic [7:0] e_cnt);
    chk({tag, " ow1 data"},  {16'h0, d1_data}, {16'h0, e_data});
    chk({tag, " ow1 valid"}, {31'h0, d1_valid}, {31'h0, e_valid});
    chk({tag, " ow1 ovr"},   {31'h0, d1_ovr},   {31'h0, e_ovr});
    chk({tag, " ow1 cnt"},   {24'h0, d1_cnt},   {24'h0, e_cnt});
    chk({tag, " ow0 valid"}, {31'h0, d0_valid}, {31'h0, e_valid});
    chk({tag, " ow0 cnt"},   {24'h0, d0_cnt},   {24'h0, e_cnt});
  endtask

  task automatic pulse_click();
    click = 1'b1;
    step(1);
    click = 1'b0;
    step(1);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    click  = 1'b0;
    sw     = 16'h0;
    rd_en  = 1'b0;
    step(3);

    // Reset state
    chk_both("reset", 16'h0, 1'b0, 1'b0, 8'd0);
    chk("reset ow0 data", {16'h0, d0_data}, 32'h0);
    chk("reset ow0 ovr", {31'h0, d0_ovr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // First capture: A5A5 after synchronizer settles
    sw = 16'hA5A5;
    step(4);
    click = 1'b1;
    step(1);
    chk_both("cap1", 16'hA5A5, 1'b1, 1'b0, 8'd1);
    chk("cap1 ow0 data", {16'h0, d0_data}, 32'h0000A5A5);
    click = 1'b0;
    step(1);

    // Read empties, data holds; a second read changes nothing
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk_both("rd1", 16'hA5A5, 1'b0, 1'b0, 8'd1);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk_both("rd2", 16'hA5A5, 1'b0, 1'b0, 8'd1);
    chk("rd2 ow0 data", {16'h0, d0_data}, 32'h0000A5A5);

    // Refill with A5A5, then click with 1234 while FULL and no read
    pulse_click();
    chk_both("refill", 16'hA5A5, 1'b1, 1'b0, 8'd2);
    sw = 16'h1234;
    step(3);
    click = 1'b1;
    step(1);
    click = 1'b0;
    chk_both("ovr", 16'h1234, 1'b1, 1'b1, 8'd3);
    chk("ovr ow0 data keeps", {16'h0, d0_data}, 32'h0000A5A5);
    chk("ovr ow0 flag", {31'h0, d0_ovr}, 32'h1);
    step(1);

    // Read clears valid and overrun
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk_both("rdovr", 16'h1234, 1'b0, 1'b0, 8'd3);
    chk("rdovr ow0 data", {16'h0, d0_data}, 32'h0000A5A5);
    chk("rdovr ow0 ovr", {31'h0, d0_ovr}, 32'h0);

    // Fill, overrun again, then read+click in the same cycle with 00FF
    pulse_click();
    pulse_click();
    chk_both("pre_sim", 16'h1234, 1'b1, 1'b1, 8'd5);
    sw = 16'h00FF;
    step(3);
    click = 1'b1;
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk_both("sim", 16'h00FF, 1'b1, 1'b0, 8'd6);
    chk("sim ow0 data", {16'h0, d0_data}, 32'h000000FF);
    chk("sim ow0 ovr", {31'h0, d0_ovr}, 32'h0);

    // Click held high for 10 cycles counts once (already high for 1)
    step(9);
    chk("hold ow1 cnt", {24'h0, d1_cnt}, 32'd6);
    click = 1'b0;
    step(1);
    chk("hold ow1 ovr", {31'h0, d1_ovr}, 32'h0);
    sw = 16'hBEEF;
    step(3);
    click = 1'b1;
    step(10);
    click = 1'b0;
    step(1);
    chk_both("hold10", 16'hBEEF, 1'b1, 1'b1, 8'd7);
    chk("hold10 ow0 data", {16'h0, d0_data}, 32'h000000FF);

    // Asynchronous reset while FULL with overrun set
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_both("areset", 16'h0, 1'b0, 1'b0, 8'd0);
    chk("areset ow0 data", {16'h0, d0_data}, 32'h0);
    chk("areset ow0 ovr", {31'h0, d0_ovr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    // 256 separate clicks wrap the counter back to 0
    for (int i = 0; i < 255; i++) begin
      pulse_click();
    end
    chk("wrap255 ow1", {24'h0, d1_cnt}, 32'd255);
    chk("wrap255 ow0", {24'h0, d0_cnt}, 32'd255);
    pulse_click();
    chk("wrap0 ow1", {24'h0, d1_cnt}, 32'd0);
    chk("wrap0 ow0", {24'h0, d0_cnt}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/switch_capture.md
# switch_capture

Consumes the one-cycle click pulse produced by the debounced button detector and captures the board switch bank at that moment into a register the CPU reads over memory-mapped I/O. Provides a valid flag, a sticky overrun flag and a wrapping click counter, so software can poll for "user pressed confirm" and read the entered value exactly once. Sits between the button debouncer output and the CPU's I/O read mux.

## Interface
- `SW_W`, 16: width of the switch bank and of the captured data.
- `OVERWRITE`, 1: 1 = a click while FULL replaces the held data; 0 = the held data is kept and the new sample is dropped.
- `CNT_W`, 8: width of the click counter.

- `clk`  in  1  system clock (100 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `click`  in  1  click pulse from the debouncer; nominally one cycle high, but any length is tolerated.
- `sw`  in  SW_W  raw switch levels, asynchronous to `clk`.
- `rd_en`  in  1  CPU read strobe for the data register; one cycle per read.
- `data`  out  SW_W  captured switch value.
- `valid`  out  1  captured value not yet read.
- `overrun`  out  1  sticky flag: a click arrived while `valid`=1 and no read was in the same cycle.
- `click_cnt`  out  CNT_W  number of accepted clicks, modulo 2^CNT_W.

## Operation
- `sw` passes through a 2-flop synchronizer (`sw_s`). Captures always use `sw_s`, never raw `sw`.
- Click edge detect: `click_d` registers `click`. An accepted click is `acc = click & ~click_d`. A pulse held high for several cycles counts once.
- The FSM has two states, EMPTY (`valid`=0) and FULL (`valid`=1). `valid` is the state bit.
- EMPTY, `acc`=1: `data` <= `sw_s`, go to FULL.
- EMPTY, `rd_en`=1: no effect (the read returns stale `data`, `valid` stays 0).
- FULL, `rd_en`=1, `acc`=0: go to EMPTY and clear `overrun`. `data` holds its value.
- FULL, `acc`=1, `rd_en`=0: set `overrun`=1 and stay FULL. `data` <= `sw_s` if OVERWRITE=1, otherwise it is unchanged.
- FULL, `acc`=1, `rd_en`=1 in the same cycle: the read consumes the old value and the click is captured.
  - `data` <= `sw_s` regardless of OVERWRITE.
  - State stays FULL.
  - `overrun` is cleared. Clear takes priority over set in this case.
- `click_cnt` increments on every `acc`, in any state, and wraps from 2^CNT_W−1 to 0. Reads do not affect it.
- Outputs are driven directly from registers; there is no combinational path from input to output.

## Timing
- Reset (`rst_n`=0, asynchronous) forces `data`=0, `valid`=0, `overrun`=0, `click_cnt`=0, `click_d`=0 and the synchronizer flops to 0.
  - Reset asserted mid-operation discards any held value immediately, with no wait for a clock edge.
  - After deassertion, the first accepted click requires `click` rising while `click_d`=0.
- Click latency: `click` rises at edge N. At edge N+1, `data` and `valid` are updated and `click_cnt` is incremented.
- Switch latency: `sw` must be stable 2 cycles before the click edge for that value to be captured. The debouncer's ≥20 ms filter guarantees this in practice.
- Read: `rd_en` is sampled at edge N. `valid` and `overrun` reflect the clear after edge N.
  - The CPU samples `data` during the `rd_en` cycle itself.
  - Therefore `data` must not change on a read.
- Throughput: one accepted click per 2 cycles at most, because of the edge detect.

## Test plan
- Reset, then `sw`=16'hA5A5 held for 4 cycles, then `click` high for 1 cycle -> after 1 edge, `data`=A5A5, `valid`=1, `click_cnt`=1, `overrun`=0.
- From that state, `rd_en` for 1 cycle -> `valid`=0, `data` still A5A5. A second `rd_en` -> no change.
- FULL with `data`=A5A5, `sw`=16'h1234, click with no read:
  - OVERWRITE=1 -> `data`=1234, `overrun`=1, `valid`=1.
  - OVERWRITE=0 -> `data`=A5A5, `overrun`=1.
  - A following `rd_en` clears both `valid` and `overrun`.
- FULL, with `click` rising and `rd_en` in the same cycle and `sw`=16'h00FF -> `data`=00FF, `valid`=1, `overrun`=0.
- `click` held high for 10 cycles -> exactly one capture and `click_cnt`+1. Then 256 separate clicks from `click_cnt`=0 -> `click_cnt` wraps to 0.
- Async reset: assert `rst_n`=0 mid-cycle while FULL with `overrun`=1 -> all outputs are 0 before the next `clk` edge.
